// File: rtl/tfr_value_skid_pkg.sv
// Shared constants and helpers for the toggle-handshake value transfer blocks.
`timescale 1ns/100ps
package tfr_pkg;

  localparam int unsigned NFF_MIN = 2;
  localparam int unsigned NFF_MAX = 4;

  // A-side action decoded each cycle from idle, skid state and source valid.
  typedef enum logic [1:0] {
    A_HOLD,
    A_LAUNCH_IN,
    A_LOAD_SKID,
    A_LAUNCH_SKID
  } a_act_e;

  function automatic bit nff_ok(input int unsigned n);
    return (n >= NFF_MIN) && (n <= NFF_MAX);
  endfunction

endpackage

// File: rtl/tfr_value_skid_sync_bit.sv
// NFF-flop single-bit synchroniser with asynchronous active-low reset.
`timescale 1ns/100ps
module tfr_sync_bit
  import tfr_pkg::*;
#(
  parameter int unsigned NFF = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  generate
    if (!nff_ok(NFF)) begin : g_bad_nff
      $error("tfr_sync_bit: NFF must be in 2..4");
    end
  endgenerate

  logic [NFF-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[NFF-2:0], i_d};
    end
  end

  assign o_q = r_sync[NFF-1];

endmodule

// File: rtl/tfr_value_skid.sv
// Toggle-handshake transfer of one W-bit word from domain A to domain B.
// Optional A-side skid register enabled by defining TFR_SKID_EN.
`timescale 1ns/100ps
module tfr_value_skid
  import tfr_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned NFF   = 2,
  parameter int unsigned LGCNT = 16
) (
  input  logic             i_a_clk,
  input  logic             i_a_reset_n,
  input  logic             i_b_clk,
  input  logic             i_b_reset_n,
  input  logic             i_a_valid,
  output logic             o_a_ready,
  input  logic [W-1:0]     i_a_data,
  output logic             o_a_busy,
  output logic             o_b_valid,
  input  logic             i_b_ready,
  output logic [W-1:0]     o_b_data,
  output logic [LGCNT-1:0] o_b_count
);

  generate
    if (!nff_ok(NFF)) begin : g_bad_nff
      $error("tfr_value_skid: NFF must be in 2..4");
    end
  endgenerate

  // ---------------- A domain ----------------
  logic         r_a_req;
  logic [W-1:0] r_a_data = '0;
  logic         w_a_ack;
  logic         w_a_idle;
  logic         w_a_launch;
  logic [W-1:0] w_launch_data;
  a_act_e       w_a_act;

  assign w_a_idle = (w_a_ack == r_a_req);

`ifdef TFR_SKID_EN
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;

  // A held skid word always launches before any new word is taken.
  always_comb begin
    w_a_act = A_HOLD;
    if (w_a_idle && r_skid_valid) begin
      w_a_act = A_LAUNCH_SKID;
    end else if (i_a_valid && !r_skid_valid) begin
      w_a_act = w_a_idle ? A_LAUNCH_IN : A_LOAD_SKID;
    end
  end

  always_comb begin
    w_launch_data = i_a_data;
    if (w_a_act == A_LAUNCH_SKID) begin
      w_launch_data = r_skid_data;
    end
  end

  always_ff @(posedge i_a_clk or negedge i_a_reset_n) begin
    if (!i_a_reset_n) begin
      r_skid_valid <= 1'b0;
    end else if (w_a_act == A_LOAD_SKID) begin
      r_skid_valid <= 1'b1;
    end else if (w_a_act == A_LAUNCH_SKID) begin
      r_skid_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_a_clk) begin
    if (w_a_act == A_LOAD_SKID) begin
      r_skid_data <= i_a_data;
    end
  end

  assign o_a_ready = !r_skid_valid;
  assign o_a_busy  = !w_a_idle || r_skid_valid;
`else
  always_comb begin
    w_a_act = A_HOLD;
    if (i_a_valid && w_a_idle) begin
      w_a_act = A_LAUNCH_IN;
    end
  end

  assign w_launch_data = i_a_data;
  assign o_a_ready     = w_a_idle;
  assign o_a_busy      = !w_a_idle;
`endif

  assign w_a_launch = (w_a_act == A_LAUNCH_IN) || (w_a_act == A_LAUNCH_SKID);

  always_ff @(posedge i_a_clk or negedge i_a_reset_n) begin
    if (!i_a_reset_n) begin
      r_a_req <= 1'b0;
    end else if (w_a_launch) begin
      r_a_req <= !r_a_req;
    end
  end

  // Launch register is only written here, so it is stable while the request is outstanding.
  always_ff @(posedge i_a_clk) begin
    if (w_a_launch) begin
      r_a_data <= w_launch_data;
    end
  end

  // ---------------- B domain ----------------
  logic             w_b_req;
  logic             w_b_stb;
  logic             w_b_adv;
  logic             r_b_last;
  logic             r_b_valid;
  logic [W-1:0]     r_b_data = '0;
  logic [LGCNT-1:0] r_b_count;

  tfr_sync_bit #(.NFF(NFF)) u_sync_req (
    .i_clk     (i_b_clk),
    .i_reset_n (i_b_reset_n),
    .i_d       (r_a_req),
    .o_q       (w_b_req)
  );

  tfr_sync_bit #(.NFF(NFF)) u_sync_ack (
    .i_clk     (i_a_clk),
    .i_reset_n (i_a_reset_n),
    .i_d       (r_b_last),
    .o_q       (w_a_ack)
  );

  assign w_b_stb = (r_b_last != w_b_req);
  assign w_b_adv = !r_b_valid || i_b_ready;

  // Holding r_b_last while stalled is what withholds the ack from A.
  always_ff @(posedge i_b_clk or negedge i_b_reset_n) begin
    if (!i_b_reset_n) begin
      r_b_valid <= 1'b0;
      r_b_last  <= 1'b0;
      r_b_count <= '0;
    end else begin
      if (w_b_adv) begin
        r_b_valid <= w_b_stb;
        r_b_last  <= w_b_req;
      end
      if (r_b_valid && i_b_ready) begin
        r_b_count <= r_b_count + 1'b1;
      end
    end
  end

  always_ff @(posedge i_b_clk) begin
    if (w_b_adv && w_b_stb) begin
      r_b_data <= r_a_data;
    end
  end

  assign o_b_valid = r_b_valid;
  assign o_b_data  = r_b_data;
  assign o_b_count = r_b_count;

endmodule

// File: tb/tb_tfr_value_skid.sv
// Self-checking bench for tfr_value_skid: directed steps plus randomized traffic against a word-queue model.
`timescale 1ns/100ps
module tb_tfr_value_skid;

  localparam int unsigned W     = 32;
  localparam int unsigned NFF   = 2;
  localparam int unsigned LGCNT = 4;

  logic             i_a_clk = 1'b0;
  logic             i_b_clk = 1'b0;
  logic             i_a_reset_n = 1'b0;
  logic             i_b_reset_n = 1'b0;
  logic             i_a_valid = 1'b0;
  logic             o_a_ready;
  logic [W-1:0]     i_a_data = '0;
  logic             o_a_busy;
  logic             o_b_valid;
  logic             i_b_ready = 1'b1;
  logic [W-1:0]     o_b_data;
  logic [LGCNT-1:0] o_b_count;

  always #5   i_a_clk = !i_a_clk;
  always #8.5 i_b_clk = !i_b_clk;

  tfr_value_skid #(.W(W), .NFF(NFF), .LGCNT(LGCNT)) dut (
    .i_a_clk     (i_a_clk),
    .i_a_reset_n (i_a_reset_n),
    .i_b_clk     (i_b_clk),
    .i_b_reset_n (i_b_reset_n),
    .i_a_valid   (i_a_valid),
    .o_a_ready   (o_a_ready),
    .i_a_data    (i_a_data),
    .o_a_busy    (o_a_busy),
    .o_b_valid   (o_b_valid),
    .i_b_ready   (i_b_ready),
    .o_b_data    (o_b_data),
    .o_b_count   (o_b_count)
  );

  int unsigned      n_checks = 0;
  int unsigned      n_errors = 0;
  logic [W-1:0]     exp_q[$];
  logic [LGCNT-1:0] exp_count = '0;
  int unsigned      bedges = 0;
  int unsigned      acc_edge = 0;
  logic             prev_stall = 1'b0;
  logic [W-1:0]     prev_data = '0;
  logic             rnd_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge i_b_clk) bedges <= bedges + 1;

  // B-side monitor: every delivery must be the oldest accepted word, exactly once.
  always @(negedge i_b_clk) begin
    if (!i_b_reset_n) begin
      prev_stall = 1'b0;
    end else begin
      check("b_count", 64'(o_b_count), 64'(exp_count));
      if (prev_stall) begin
        check("b_hold_valid", 64'(o_b_valid), 64'd1);
        check("b_hold_data", 64'(o_b_data), 64'(prev_data));
      end
      if (o_b_valid && i_b_ready) begin
        check("b_word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          check("b_data_order", 64'(o_b_data), 64'(exp_q.pop_front()));
        end
        exp_count = exp_count + 1'b1;
      end
      prev_stall = o_b_valid && !i_b_ready;
      prev_data  = o_b_data;
    end
  end

  // Present one word and hold it until accepted; called just after an A posedge.
  task automatic send(input logic [W-1:0] w);
    int unsigned n;
    n = 0;
    i_a_valid = 1'b1;
    i_a_data  = w;
    @(negedge i_a_clk);
    while (!o_a_ready && n < 400) begin
      check("a_notready_busy", 64'(o_a_busy), 64'd1);
      @(negedge i_a_clk);
      n++;
    end
    check("a_accept_timeout", 64'(n < 400), 64'd1);
    @(posedge i_a_clk);
    if (o_a_ready) begin
      exp_q.push_back(w);
      acc_edge = bedges;
    end
    #1;
    i_a_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || o_a_busy) && n < 3000) begin
      @(negedge i_b_clk);
      n++;
    end
    repeat (6) @(negedge i_b_clk);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_a_idle", 64'(o_a_busy), 64'd0);
  endtask

  task automatic set_b_ready(input logic v);
    @(posedge i_b_clk);
    #1;
    i_b_ready = v;
  endtask

  initial begin
    int unsigned  n;
    int unsigned  lat;
    logic [W-1:0] w;

    // Reset state, with both resets asserted together and released independently.
    #20;
    check("rst_a_ready", 64'(o_a_ready), 64'd1);
    check("rst_a_busy", 64'(o_a_busy), 64'd0);
    check("rst_b_valid", 64'(o_b_valid), 64'd0);
    check("rst_b_count", 64'(o_b_count), 64'd0);
    check("rst_b_data", 64'(o_b_data), 64'd0);
    #22 i_a_reset_n = 1'b1;
    #13 i_b_reset_n = 1'b1;
    repeat (3) @(posedge i_a_clk);
    #1;
    check("post_rst_a_ready", 64'(o_a_ready), 64'd1);

    // Single word: latency and acknowledge.
    send(32'hDEADBEEF);
    n = 0;
    while (!o_b_valid && n < 20) begin
      @(negedge i_b_clk);
      n++;
    end
    lat = bedges - acc_edge;
    check("lat_in_window", 64'((lat >= NFF + 1) && (lat <= NFF + 2)), 64'd1);
    check("single_data", 64'(o_b_data), 64'hDEADBEEF);
    n = 0;
    while (o_a_busy && n < 100) begin
      @(negedge i_a_clk);
      n++;
    end
    check("single_ack_ready", 64'(o_a_ready), 64'd1);
    check("single_ack_busy", 64'(o_a_busy), 64'd0);
    @(negedge i_b_clk);
    check("single_count", 64'(o_b_count), 64'd1);

    // Back-to-back words 0..7 with the sink always ready.
    @(posedge i_a_clk);
    #1;
    for (int i = 0; i < 8; i++) send(W'(i));
    drain();
    check("b2b_count", 64'(o_b_count), 64'd9);

    // Sink stall with words pending: output must hold, source must stall.
    set_b_ready(1'b0);
    @(posedge i_a_clk);
    #1;
    send(32'h5);
    send(32'h6);
`ifdef TFR_SKID_EN
    send(32'h7);
`endif
    n = 0;
    while (!o_b_valid && n < 20) begin
      @(negedge i_b_clk);
      n++;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge i_b_clk);
      check("stall_valid", 64'(o_b_valid), 64'd1);
      check("stall_data", 64'(o_b_data), 64'h5);
    end
    @(negedge i_a_clk);
    check("stall_a_ready", 64'(o_a_ready), 64'd0);
    check("stall_a_busy", 64'(o_a_busy), 64'd1);
    set_b_ready(1'b1);
    drain();
`ifdef TFR_SKID_EN
    check("stall_count", 64'(o_b_count), 64'd12);
`else
    check("stall_count", 64'(o_b_count), 64'd11);
`endif

    // Reset both domains with words in flight; none may surface afterwards.
    set_b_ready(1'b0);
    @(posedge i_a_clk);
    #1;
    send(32'hC);
    send(32'hB);
`ifdef TFR_SKID_EN
    send(32'hA);
`endif
    repeat (10) @(posedge i_a_clk);
    #1;
    i_a_reset_n = 1'b0;
    i_b_reset_n = 1'b0;
    exp_q.delete();
    exp_count = '0;
    repeat (5) @(posedge i_a_clk);
    #1 i_a_reset_n = 1'b1;
    set_b_ready(1'b1);
    i_b_reset_n = 1'b1;
    repeat (40) @(negedge i_b_clk);
    check("mid_rst_b_valid", 64'(o_b_valid), 64'd0);
    check("mid_rst_b_count", 64'(o_b_count), 64'd0);
    check("mid_rst_a_ready", 64'(o_a_ready), 64'd1);
    check("mid_rst_a_busy", 64'(o_a_busy), 64'd0);

    // 17 random words with random sink stalls: counter wraps to 1.
    rnd_done = 1'b0;
    fork
      begin
        @(posedge i_a_clk);
        #1;
        for (int i = 0; i < 17; i++) send(W'($urandom));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) set_b_ready(($urandom_range(0, 3)) != 0);
      end
    join
    set_b_ready(1'b1);
    drain();
    check("wrap_count", 64'(o_b_count), 64'd1);

    // 100 random transfers with random source gaps and sink stalls.
    rnd_done = 1'b0;
    fork
      begin
        @(posedge i_a_clk);
        #1;
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge i_a_clk);
            #1;
          end
          w = W'($urandom);
          send(w);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) set_b_ready(($urandom_range(0, 2)) != 0);
      end
    join
    set_b_ready(1'b1);
    drain();
    check("rand_final_count", 64'(o_b_count), 64'(LGCNT'(117)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
